// File: rtl/hdmi_pattern_generator.sv
// Test-pattern pixel source for the 720p HDMI link: re-times hsync/vsync/DE by
// two cycles and emits solid, colour-bar, gradient or bouncing-box pixels.
module hdmi_pattern_generator #(
  parameter int          H_ACTIVE    = 1280,
  parameter int          V_ACTIVE    = 720,
  parameter int          BOX_SIZE    = 64,
  parameter int          BOX_STEP    = 4,
  parameter logic [23:0] SOLID_COLOR = 24'hFF6432,
  parameter logic [23:0] BOX_COLOR   = 24'hFFFFFF
) (
  input  logic        clock74,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  input  logic [1:0]  pattern_sel,
  output logic        hsync,
  output logic        vsync,
  output logic        data_enable,
  output logic [23:0] rgb_data
);
  localparam logic [10:0] LIM_X    = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] LIM_Y    = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP     = 11'(BOX_STEP);
  localparam logic [11:0] SIZE     = 12'(BOX_SIZE);
  localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);
  localparam logic [10:0] Y_MAX    = 11'h7FF;

  typedef enum logic {DIR_POS, DIR_NEG} dir_t;
  typedef struct packed {
    dir_t        dir;
    logic [10:0] pos;
  } axis_t;

  // One frame of box motion on one axis: clamp at the limit and bounce.
  function automatic axis_t step_axis(axis_t a, logic [10:0] lim);
    axis_t r;
    r = a;
    if (a.dir == DIR_POS) begin
      if ({1'b0, a.pos} + {1'b0, STEP} > {1'b0, lim}) begin
        r.pos = lim;
        r.dir = DIR_NEG;
      end else begin
        r.pos = a.pos + STEP;
      end
    end else begin
      if (a.pos < STEP) begin
        r.pos = '0;
        r.dir = DIR_POS;
      end else begin
        r.pos = a.pos - STEP;
      end
    end
    return r;
  endfunction

  function automatic logic [23:0] bar_color(logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  logic        hs_s1, vs_s1, de_s1;
  logic [10:0] x, y, bar_cnt;
  logic [2:0]  bar_idx;
  logic [7:0]  frame;
  logic [1:0]  active_sel;
  axis_t       box_x, box_y;
  logic        vs_rise;
  logic        in_box;
  logic [23:0] pixel;

  assign vs_rise = vsync_in & ~vs_s1;

  // Stage 1: registered syncs, pixel coordinates and per-frame state.
  // NOTE: every register in a clocked block uses <= so all flops update from
  // pre-edge values; a blocking assignment here would chain stages together.
  always_ff @(posedge clock74) begin
    if (reset) begin
      // NOTE: all state, not just the outputs, is cleared so a mid-frame reset
      // restarts the pattern from a known origin.
      hs_s1      <= 1'b0;
      vs_s1      <= 1'b0;
      de_s1      <= 1'b0;
      x          <= '0;
      y          <= '0;
      bar_cnt    <= '0;
      bar_idx    <= '0;
      frame      <= '0;
      active_sel <= '0;
      box_x      <= '{DIR_POS, 11'd0};
      box_y      <= '{DIR_POS, 11'd0};
    end else begin
      hs_s1 <= hsync_in;
      vs_s1 <= vsync_in;
      de_s1 <= de_in;
      if (vs_rise) begin
        // Frame boundary wins over any line activity in the same cycle.
        x          <= '0;
        y          <= '0;
        bar_cnt    <= '0;
        bar_idx    <= '0;
        frame      <= frame + 8'd1;
        active_sel <= pattern_sel;
        box_x      <= step_axis(box_x, LIM_X);
        box_y      <= step_axis(box_y, LIM_Y);
      end else if (de_in && de_s1) begin
        x <= x + 11'd1;
        if (bar_cnt == BAR_LAST) begin
          bar_cnt <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + 11'd1;
        end
      end else begin
        x       <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
        if (de_s1 && !de_in && y != Y_MAX) y <= y + 11'd1;
      end
    end
  end

  assign in_box = (x >= box_x.pos) && ({1'b0, x} < {1'b0, box_x.pos} + SIZE) &&
                  (y >= box_y.pos) && ({1'b0, y} < {1'b0, box_y.pos} + SIZE);

  // NOTE: pixel gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pixel = '0;
    if (de_s1) begin
      case (active_sel)
        2'd0:    pixel = SOLID_COLOR;
        2'd1:    pixel = bar_color(bar_idx);
        2'd2:    pixel = {x[7:0], y[7:0], frame};
        default: pixel = in_box ? BOX_COLOR : 24'h000000;
      endcase
    end
  end

  // Stage 2: colour register, syncs re-timed to match.
  always_ff @(posedge clock74) begin
    if (reset) begin
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      data_enable <= 1'b0;
      rgb_data    <= '0;
    end else begin
      hsync       <= hs_s1;
      vsync       <= vs_s1;
      data_enable <= de_s1;
      rgb_data    <= pixel;
    end
  end
endmodule
